// File: rtl/hilo_muldiv_unit.sv
// HI/LO register file with a single-cycle multiplier, a 32-iteration
// radix-2 restoring divider, and MTHI/MTLO/MFHI/MFLO access.
module hilo_muldiv_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid,
  input  logic        flush,
  input  logic [5:0]  funct,
  input  logic [1:0]  HILO_en,
  input  logic        is_dataMovWrite,
  input  logic        is_dataMovRead,
  input  logic [31:0] srcA,
  input  logic [31:0] srcB,
  output logic [31:0] hilo_rdata,
  output logic        stall,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out
);

  localparam int unsigned W  = 32;
  localparam int unsigned CW = 5;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e          state_q;
  logic [CW-1:0]   cnt_q;
  logic [W-1:0]    hi_q;
  logic [W-1:0]    lo_q;
  logic [W-1:0]    rem_q;
  logic [W-1:0]    quo_q;
  logic [W-1:0]    dvs_q;
  logic [W-1:0]    araw_q;
  logic            qneg_q;
  logic            rneg_q;
  logic            zero_q;

  logic            op_md;
  logic            op_mt;
  logic            start_div;
  logic            a_neg;
  logic            b_neg;
  logic [W-1:0]    a_mag;
  logic [W-1:0]    b_mag;
  logic [2*W-1:0]  a_ext;
  logic [2*W-1:0]  b_ext;
  logic [2*W-1:0]  prod;
  logic [W:0]      partial;
  logic [W:0]      diff;
  logic            take;
  logic [W-1:0]    rem_d;
  logic [W-1:0]    quo_d;
  logic [W-1:0]    q_fix;
  logic [W-1:0]    r_fix;
  logic            unused_funct;

  assign unused_funct = ^funct[5:2];

  // Instruction decode for the execute stage.
  always_comb begin
    op_md     = valid & ~flush & (HILO_en == 2'b11) & ~is_dataMovWrite & ~is_dataMovRead;
    op_mt     = valid & ~flush & is_dataMovWrite;
    start_div = (state_q == S_IDLE) & op_md & funct[1];
  end

  // Operand conditioning: extension for the multiplier, magnitudes for the divider.
  always_comb begin
    a_neg = ~funct[0] & srcA[W-1];
    b_neg = ~funct[0] & srcB[W-1];
    a_mag = a_neg ? (~srcA + W'(1)) : srcA;
    b_mag = b_neg ? (~srcB + W'(1)) : srcB;
    a_ext = {{W{a_neg}}, srcA};
    b_ext = {{W{b_neg}}, srcB};
    prod  = a_ext * b_ext;
  end

  // One restoring-division step plus the final sign fix-up.
  always_comb begin
    partial = {rem_q, quo_q[W-1]};
    diff    = partial - {1'b0, dvs_q};
    take    = ~diff[W];
    rem_d   = take ? diff[W-1:0] : partial[W-1:0];
    quo_d   = {quo_q[W-2:0], take};
    q_fix   = qneg_q ? (~quo_q + W'(1)) : quo_q;
    r_fix   = rneg_q ? (~rem_q + W'(1)) : rem_q;
  end

  // Pipeline hold: issue cycle plus every RUN cycle, released by flush or reset.
  always_comb begin
    stall = ~rst & (start_div | ((state_q == S_RUN) & ~flush));
  end

  // MF read port; no bypass of a write landing at the next edge.
  always_comb begin
    hilo_rdata = HILO_en[1] ? hi_q : lo_q;
  end

  assign hi_out = hi_q;
  assign lo_out = lo_q;

  // Divider FSM, datapath and HI/LO registers. Outside IDLE the held
  // instruction is the division itself, so MT/MULT only act in IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      araw_q  <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (op_mt) begin
            if (HILO_en[1]) hi_q <= srcA;
            if (HILO_en[0]) lo_q <= srcA;
          end else if (op_md & ~funct[1]) begin
            hi_q <= prod[2*W-1:W];
            lo_q <= prod[W-1:0];
          end else if (start_div) begin
            state_q <= S_RUN;
            cnt_q   <= '0;
            rem_q   <= '0;
            quo_q   <= a_mag;
            dvs_q   <= b_mag;
            araw_q  <= srcA;
            qneg_q  <= a_neg ^ b_neg;
            rneg_q  <= a_neg;
            zero_q  <= (srcB == '0);
          end
        end
        S_RUN: begin
          if (flush) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
          end else begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            cnt_q <= cnt_q + CW'(1);
            if (cnt_q == CW'(W - 1)) state_q <= S_DONE;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          cnt_q   <= '0;
          if (!flush) begin
            if (zero_q) begin
              hi_q <= araw_q;
              lo_q <= '1;
            end else begin
              hi_q <= r_fix;
              lo_q <= q_fix;
            end
          end
        end
        default: begin
          state_q <= S_IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

endmodule
